// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM
// Outputs decode combinationally from the current state and mem_ready, and are forced low while reset is high.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic       branch,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        branch     = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = 2'b00;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal_op = !(op == OP_LW || op == OP_SW || op == OP_RTYPE ||
                                   op == OP_BEQ || op == OP_ADDI || op == OP_J);
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = 2'b10;
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = 2'b01;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed bench for mc_controller
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, branch;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       illegal_op;
    logic [3:0] state;

    int passed = 0;
    int total  = 0;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .irwrite(irwrite), .regwrite(regwrite), .memwrite(memwrite),
        .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg), .branch(branch),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // {pcwrite,irwrite,regwrite,memwrite,iord,alusrca,regdst,memtoreg,branch,alusrcb,pcsrc,aluop,illegal_op}
    logic [15:0] ctrl;
    assign ctrl = {pcwrite, irwrite, regwrite, memwrite, iord, alusrca, regdst, memtoreg, branch,
                   alusrcb, pcsrc, aluop, illegal_op};

    localparam logic [15:0] E_ZERO    = 16'h0000;
    localparam logic [15:0] E_FETCH   = {9'b110000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_FSTALL  = {9'b000000000, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_DECODE  = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_DEC_ILL = {9'b000000000, 2'b11, 2'b00, 2'b00, 1'b1};
    localparam logic [15:0] E_MEMADR  = {9'b000001000, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMRD   = {9'b000010000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWB   = {9'b001000010, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_MEMWR   = {9'b000110000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_EXEC    = {9'b000001000, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [15:0] E_ALUWB   = {9'b001000100, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_BRANCH  = {9'b000001001, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [15:0] E_ADDIWB  = {9'b001000000, 2'b00, 2'b00, 2'b00, 1'b0};
    localparam logic [15:0] E_JUMP    = {9'b100000000, 2'b00, 2'b10, 2'b00, 1'b0};

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RT = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = OP_LW; mem_ready = 1'b1;
        tick(); tick();
        total++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state);
        else passed++;
        total++;
        if (ctrl !== E_ZERO) $display("FAIL reset_ctrl: got %h expected %h", ctrl, E_ZERO);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (ctrl !== E_FETCH) $display("FAIL reset_release_fetch: got %h expected %h", ctrl, E_FETCH);
        else passed++;
    endtask

    task automatic test_lw();
        logic [3:0]  st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        logic [15:0] ex [6] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_FETCH};
        op = OP_LW; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL lw cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 5) tick();
        end
    endtask

    task automatic test_rtype_beq();
        logic [3:0]  st [9] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd8, 4'd0, 4'd1};
        logic [15:0] ex [9] = '{E_FETCH, E_DECODE, E_EXEC, E_ALUWB, E_FETCH, E_DECODE, E_BRANCH, E_FETCH, E_DECODE};
        logic [5:0]  o  [9] = '{OP_RT, OP_RT, OP_RT, OP_RT, OP_BEQ, OP_BEQ, OP_BEQ, OP_ADDI, OP_ADDI};
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            op = o[i];
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL rtype_beq cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            tick();
        end
    endtask

    task automatic test_addi();
        logic [3:0]  st [3] = '{4'd9, 4'd10, 4'd0};
        logic [15:0] ex [3] = '{E_MEMADR, E_ADDIWB, E_FETCH};
        op = OP_ADDI; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL addi cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 2) tick();
        end
    endtask

    task automatic test_sw_stall();
        logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        logic [15:0] ex [8] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_MEMWR, E_MEMWR, E_MEMWR, E_FETCH};
        logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        op = OP_SW;
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL sw_stall cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 7) tick();
        end
    endtask

    task automatic test_fetch_stall();
        logic [3:0]  st [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd11, 4'd0};
        logic [15:0] ex [6] = '{E_FSTALL, E_FSTALL, E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        logic        mr [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = OP_J;
        for (int i = 0; i < 6; i++) begin
            mem_ready = mr[i];
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL fetch_stall cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 5) tick();
        end
    endtask

    task automatic test_illegal();
        logic [3:0]  st [3] = '{4'd0, 4'd1, 4'd0};
        logic [15:0] ex [3] = '{E_FETCH, E_DEC_ILL, E_FETCH};
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL illegal cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 2) tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0]  st [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [15:0] ex [4] = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMRD};
        logic [3:0]  jst [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
        logic [15:0] jex [4] = '{E_FETCH, E_DECODE, E_JUMP, E_FETCH};
        op = OP_LW;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i < 3);
            #1;
            total++;
            if (state !== st[i] || ctrl !== ex[i])
                $display("FAIL rst_mid_lw cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, st[i], ex[i]);
            else passed++;
            if (i < 3) tick();
        end
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd3 || ctrl !== E_ZERO)
            $display("FAIL rst_mid_assert: state=%0d ctrl=%h expected state=3 ctrl=%h", state, ctrl, E_ZERO);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            mem_ready = 1'b1;
            tick();
            total++;
            if (state !== 4'd0 || ctrl !== E_ZERO)
                $display("FAIL rst_mid_hold%0d: state=%0d ctrl=%h expected state=0 ctrl=%h", i, state, ctrl, E_ZERO);
            else passed++;
        end
        reset = 1'b0;
        op = OP_J;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (state !== jst[i] || ctrl !== jex[i])
                $display("FAIL rst_mid_j cyc%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, jst[i], jex[i]);
            else passed++;
            if (i < 3) tick();
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype_beq();
        test_addi();
        test_sw_stall();
        test_fetch_stall();
        test_illegal();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
